// File: rtl/msx_slot_config_mgr.sv
// Per-slot cartridge configuration decoder. Registers decoded type/mapper/SRAM settings and
// raises a debounced reload request once a changed configuration has been stable long enough.
module msx_slot_config_mgr #(
    parameter int         SLOTS         = 2,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         FDC_SLOT      = 0,
    parameter logic [7:0] MAX_TYP_MASK  = 8'h7F,
    parameter logic [3:0] SRAM_MASK     = 4'b0001
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic                 bios_use_fdc,
    input  logic [SLOTS-1:0]     rom_loaded,
    input  logic [3*SLOTS-1:0]   typ_raw,
    input  logic [4*SLOTS-1:0]   mapper_raw,
    input  logic [3*SLOTS-1:0]   sram_raw,
    output logic [3*SLOTS-1:0]   cart_typ,
    output logic [4*SLOTS-1:0]   cart_mapper,
    output logic [8*SLOTS-1:0]   cart_sram,
    output logic [SLOTS-1:0]     rom_hide,
    output logic [SLOTS-1:0]     sram_hide,
    output logic                 fdc_enabled,
    output logic                 reload_req,
    output logic [SLOTS-1:0]     reload_mask,
    input  logic                 reload_ack
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_REQ    = 2'd3;

    logic [3*SLOTS-1:0]  typ_d, cart_typ_q;
    logic [4*SLOTS-1:0]  map_d, cart_mapper_q;
    logic [8*SLOTS-1:0]  sram_d, cart_sram_q;
    logic [SLOTS-1:0]    rom_hide_d, rom_hide_q, sram_hide_d, sram_hide_q;
    logic [SLOTS-1:0]    slot_chg, mask_d, mask_q;
    logic [10*SLOTS-1:0] cfg_d, cfg_q, commit_d, commit_q, snap_d, snap_q;
    logic                fdc_d, fdc_q;
    logic [1:0]          state_d, state_q;
    logic [CW-1:0]       cnt_d, cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            localparam logic [7:0] LEGAL = (gi == FDC_SLOT) ? MAX_TYP_MASK : 8'h0F;
            logic [2:0] t_raw, s_raw, t;
            logic [3:0] m_raw;
            logic       sram_ok;

            assign t_raw = typ_raw[3*gi +: 3];
            assign m_raw = mapper_raw[4*gi +: 4];
            assign s_raw = sram_raw[3*gi +: 3];

            // FDC is only usable when the BIOS does not already supply one
            assign t = (LEGAL[t_raw] && !(t_raw == 3'd6 && bios_use_fdc)) ? t_raw : 3'd7;
            assign sram_ok = (t == 3'd0) && (m_raw > 4'd1) && (s_raw != 3'd0) &&
                             (s_raw != 3'd7) && SRAM_MASK[gi];

            assign typ_d[3*gi +: 3]  = t;
            assign map_d[4*gi +: 4]  = rom_loaded[gi] ? m_raw + 4'd2 : 4'd0;
            assign sram_d[8*gi +: 8] = sram_ok ? (8'd1 << (s_raw - 3'd1)) : 8'd0;
            assign rom_hide_d[gi]    = (t != 3'd0);
            assign sram_hide_d[gi]   = (t != 3'd0) || (m_raw == 4'd0) || !SRAM_MASK[gi];
            assign cfg_d[10*gi +: 10] = {t, map_d[4*gi +: 4], s_raw};
            assign slot_chg[gi]      = (cfg_q[10*gi +: 10] != commit_q[10*gi +: 10]);
        end
    endgenerate

    assign fdc_d = bios_use_fdc | (typ_d[3*FDC_SLOT +: 3] == 3'd6);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_d = commit_q;
        snap_d   = snap_q;
        mask_d   = mask_q;
        case (state_q)
            ST_INIT: begin
                commit_d = cfg_d;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (cfg_d != commit_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cfg_d == commit_q) begin
                    state_d = ST_IDLE;
                end else if (cfg_d != cfg_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // counter parks at its last value while hold keeps the core in reset
                    if (!hold) begin
                        state_d = ST_REQ;
                        snap_d  = cfg_q;
                        mask_d  = slot_chg;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_REQ: begin
                if (reload_ack) begin
                    commit_d = snap_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            commit_q      <= '0;
            snap_q        <= '0;
            mask_q        <= '0;
            cfg_q         <= '0;
            cart_typ_q    <= {SLOTS{3'd7}};
            cart_mapper_q <= '0;
            cart_sram_q   <= '0;
            rom_hide_q    <= '1;
            sram_hide_q   <= '1;
            fdc_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            commit_q      <= commit_d;
            snap_q        <= snap_d;
            mask_q        <= mask_d;
            cfg_q         <= cfg_d;
            cart_typ_q    <= typ_d;
            cart_mapper_q <= map_d;
            cart_sram_q   <= sram_d;
            rom_hide_q    <= rom_hide_d;
            sram_hide_q   <= sram_hide_d;
            fdc_q         <= fdc_d;
        end
    end

    assign cart_typ    = cart_typ_q;
    assign cart_mapper = cart_mapper_q;
    assign cart_sram   = cart_sram_q;
    assign rom_hide    = rom_hide_q;
    assign sram_hide   = sram_hide_q;
    assign fdc_enabled = fdc_q;
    assign reload_req  = (state_q == ST_REQ);
    assign reload_mask = mask_q;

endmodule
